// File: rtl/uart_pkg.sv
// Shared UART constants used by the receiver, its FIFO and the benches.
`timescale 1ns/1ps
package uart_pkg;
    localparam int UART_DATA_W       = 8;
    localparam int UART_CLKS_PER_BIT = 1085;
endpackage

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
`timescale 1ns/1ps
module uart_rx_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Contents are intentionally not reset; the head is only meaningful when not empty.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO behind uart_rx with sticky overflow.
// Optional almost_full output is enabled by defining UART_RX_FIFO_AF_EN.
`timescale 1ns/1ps
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W   = UART_DATA_W,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_stb,
    input  logic              i_rd_en,
    input  logic              i_ovf_clr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_empty,
    output logic              o_full,
    output logic [CW-1:0]     o_count,
    output logic              o_overflow
`ifdef UART_RX_FIFO_AF_EN
    ,
    output logic              o_almost_full
`endif
);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_stb_q;
    logic          r_overflow;

    logic          w_wr_evt;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [CW-1:0] w_count_nxt;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));

    // A pop in the same cycle frees a slot, so a write to a full FIFO is still accepted.
    assign w_wr_evt    = i_wr_stb & ~r_stb_q;
    assign w_pop       = i_rd_en & ~o_empty;
    assign w_push      = w_wr_evt & (~o_full | w_pop);
    assign w_drop      = w_wr_evt & o_full & ~w_pop;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    // stb_q resets high so a strobe already high at release is not a write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_stb_q    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_stb_q <= i_wr_stb;
            r_count <= w_count_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_AF_EN
    logic r_almost_full;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (int'(w_count_nxt) >= AF_LEVEL);
        end
    end

    assign o_almost_full = r_almost_full;
`endif

    assign o_count    = r_count;
    assign o_overflow = r_overflow;

    uart_rx_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (o_rd_data)
    );

endmodule
